// File: rtl/hazard_state_monitor_if.sv
//==============================================================================
// Module      : hazard_state_monitor_if
// Description : Feature-stream and result bundle between the feature extractor
//               / safety output stage (master side) and hazard_state_monitor
//               (slave side).
//               Master drives: feat_accel_mag, feat_brake_rate, feat_valid,
//                              alarm_clear
//               Slave drives : avg_accel, state, warn, alarm, event_count,
//                              out_valid
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface hazard_state_monitor_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] feat_accel_mag;
  logic [DATA_WIDTH-1:0] feat_brake_rate;
  logic                  feat_valid;
  logic                  alarm_clear;
  logic [DATA_WIDTH-1:0] avg_accel;
  logic [1:0]            state;
  logic                  warn;
  logic                  alarm;
  logic [7:0]            event_count;
  logic                  out_valid;

  modport master (
    output feat_accel_mag, feat_brake_rate, feat_valid, alarm_clear,
    input  avg_accel, state, warn, alarm, event_count, out_valid
  );

  modport slave (
    input  feat_accel_mag, feat_brake_rate, feat_valid, alarm_clear,
    output avg_accel, state, warn, alarm, event_count, out_valid
  );
endinterface

`default_nettype wire

// File: rtl/hazard_state_monitor.sv
//==============================================================================
// Module      : hazard_state_monitor
// Description : Smooths acceleration over a 2^WIN_LOG2 sliding window, then
//               classifies each sample against warn/alarm thresholds with
//               hysteresis and persistence. Drives state, warn/alarm flags and
//               a saturating count of ALARM entries.
// Ports       : clk  - system clock (rising edge)
//               rst  - synchronous active-high reset
//               bus  - hazard_state_monitor_if.slave
//                      in : feat_accel_mag, feat_brake_rate, feat_valid,
//                           alarm_clear
//                      out: avg_accel, state, warn, alarm, event_count,
//                           out_valid
// Pipeline    : edge N window/sum, edge N+1 avg_accel, edge N+2 state/flags
//               and out_valid pulse.
// Option      : HAZARD_LATCH_EN - when defined, ALARM exits into HOLD and
//               stays alarmed until alarm_clear; otherwise ALARM exits to
//               WARN and alarm_clear is ignored.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module hazard_state_monitor #(
  parameter int DATA_WIDTH  = 16,
  parameter int WIN_LOG2    = 2,
  parameter int ACCEL_WARN  = 1000,
  parameter int ACCEL_ALARM = 2000,
  parameter int BRAKE_ALARM = 1500,
  parameter int HYST        = 100,
  parameter int PERSIST     = 3
) (
  input  wire logic              clk,
  input  wire logic              rst,
  hazard_state_monitor_if.slave  bus
);

  localparam int WIN   = 1 << WIN_LOG2;
  localparam int SUM_W = DATA_WIDTH + WIN_LOG2;

  // Thresholds compared in 32 bits so parameters wider than the data path
  // behave sensibly. Exit levels saturate at zero, making "< 0" unreachable.
  localparam logic [31:0] C_ACCEL_WARN  = 32'(ACCEL_WARN);
  localparam logic [31:0] C_ACCEL_ALARM = 32'(ACCEL_ALARM);
  localparam logic [31:0] C_BRAKE_ALARM = 32'(BRAKE_ALARM);
  localparam logic [31:0] C_ACCEL_WARN_EXIT =
    (ACCEL_WARN > HYST) ? 32'(ACCEL_WARN - HYST) : 32'd0;
  localparam logic [31:0] C_ACCEL_ALARM_EXIT =
    (ACCEL_ALARM > HYST) ? 32'(ACCEL_ALARM - HYST) : 32'd0;
  localparam logic [31:0] C_BRAKE_ALARM_EXIT =
    (BRAKE_ALARM > HYST) ? 32'(BRAKE_ALARM - HYST) : 32'd0;
  localparam logic [3:0]  C_PERSIST = 4'(PERSIST);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_WARN   = 2'd1,
    ST_ALARM  = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Stage 1: sliding window and running sum
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_win [WIN];
  logic [SUM_W-1:0]      r_sum;
  logic [DATA_WIDTH-1:0] r_brake1;
  logic                  r_v1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) r_win[i] <= '0;
      r_sum    <= '0;
      r_brake1 <= '0;
      r_v1     <= 1'b0;
    end else begin
      r_v1 <= bus.feat_valid;
      if (bus.feat_valid) begin
        r_win[0] <= bus.feat_accel_mag;
        for (int i = 1; i < WIN; i++) r_win[i] <= r_win[i-1];
        // Sum still contains the outgoing sample, so the subtraction never
        // underflows and the result always fits SUM_W bits.
        r_sum    <= r_sum + SUM_W'(bus.feat_accel_mag) - SUM_W'(r_win[WIN-1]);
        r_brake1 <= bus.feat_brake_rate;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered average, brake delayed to stay paired with it
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_avg;
  logic [DATA_WIDTH-1:0] r_brake2;
  logic                  r_v2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_avg    <= '0;
      r_brake2 <= '0;
      r_v2     <= 1'b0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_avg    <= r_sum[SUM_W-1:WIN_LOG2];
        r_brake2 <= r_brake1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: classification
  // ---------------------------------------------------------------------------
  logic [31:0] w_avg32;
  logic [31:0] w_brk32;
  logic        w_hot;
  logic        w_warm;
  logic        w_cool_alarm;
  logic        w_cool_warn;

  assign w_avg32      = 32'(r_avg);
  assign w_brk32      = 32'(r_brake2);
  assign w_hot        = (w_avg32 >= C_ACCEL_ALARM) || (w_brk32 >= C_BRAKE_ALARM);
  assign w_warm       = (w_avg32 >= C_ACCEL_WARN);
  assign w_cool_alarm = (w_avg32 < C_ACCEL_ALARM_EXIT) &&
                        (w_brk32 < C_BRAKE_ALARM_EXIT);
  assign w_cool_warn  = w_cool_alarm && (w_avg32 < C_ACCEL_WARN_EXIT);

  state_t     r_state;
  state_t     w_state_next;
  logic [3:0] r_pcnt;
  logic [3:0] w_pcnt_next;
  logic [3:0] w_pcnt_inc;
  logic       w_persisted;
  logic       r_last_cw;
  logic       w_last_cw_next;
  logic [7:0] r_events;
  logic [7:0] w_events_next;
  logic       r_out_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_NORMAL;
      r_pcnt      <= '0;
      r_last_cw   <= 1'b0;
      r_events    <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pcnt      <= w_pcnt_next;
      r_last_cw   <= w_last_cw_next;
      r_events    <= w_events_next;
      r_out_valid <= r_v2;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_pcnt_next    = r_pcnt;
    w_last_cw_next = r_last_cw;
    w_events_next  = r_events;

    // Persisted means the current hot sample is the PERSIST-th in a row.
    w_pcnt_inc  = (r_pcnt >= C_PERSIST) ? C_PERSIST : r_pcnt + 4'd1;
    w_persisted = w_hot && (w_pcnt_inc == C_PERSIST);

    if (r_v2) begin
      w_pcnt_next    = w_hot ? w_pcnt_inc : 4'd0;
      w_last_cw_next = w_cool_warn;
      case (r_state)
        ST_NORMAL: begin
          if (w_persisted)          w_state_next = ST_ALARM;
          else if (w_hot || w_warm) w_state_next = ST_WARN;
        end
        ST_WARN: begin
          if (w_persisted)      w_state_next = ST_ALARM;
          else if (w_cool_warn) w_state_next = ST_NORMAL;
        end
        ST_ALARM: begin
          if (w_cool_alarm) begin
`ifdef HAZARD_LATCH_EN
            w_state_next = ST_HOLD;
`else
            w_state_next = ST_WARN;
`endif
          end
        end
`ifdef HAZARD_LATCH_EN
        ST_HOLD: begin
          if (w_persisted)                           w_state_next = ST_ALARM;
          else if (bus.alarm_clear && w_cool_warn)   w_state_next = ST_NORMAL;
        end
`endif
        default: w_state_next = ST_NORMAL;
      endcase
    end
`ifdef HAZARD_LATCH_EN
    // Operator clear between samples uses the most recent sample's verdict.
    else if (r_state == ST_HOLD && bus.alarm_clear && r_last_cw) begin
      w_state_next = ST_NORMAL;
    end
`endif

    if (w_state_next == ST_ALARM && r_state != ST_ALARM && r_events != 8'hFF)
      w_events_next = r_events + 8'd1;
  end

`ifndef HAZARD_LATCH_EN
  // Clear input and last-verdict flag have no function without the latch.
  logic w_unused;
  assign w_unused = &{1'b0, bus.alarm_clear, r_last_cw};
`endif

  assign bus.avg_accel   = r_avg;
  assign bus.state       = r_state;
  assign bus.warn        = (r_state == ST_WARN);
  assign bus.alarm       = (r_state == ST_ALARM) || (r_state == ST_HOLD);
  assign bus.event_count = r_events;
  assign bus.out_valid   = r_out_valid;

endmodule

`default_nettype wire

// File: tb/tb_hazard_state_monitor.sv
//==============================================================================
// Module      : tb_hazard_state_monitor
// Description : Self-checking bench for hazard_state_monitor. Directed
//               scenarios plus a randomized run compared against a
//               sample-level reference model.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_hazard_state_monitor;

  localparam int DW          = 16;
  localparam int WIN_LOG2    = 2;
  localparam int ACCEL_WARN  = 1000;
  localparam int ACCEL_ALARM = 2000;
  localparam int BRAKE_ALARM = 1500;
  localparam int HYST        = 100;
  localparam int PERSIST     = 3;
`ifdef HAZARD_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_state_monitor_if #(.DATA_WIDTH(DW)) bus();

  hazard_state_monitor #(
    .DATA_WIDTH (DW),
    .WIN_LOG2   (WIN_LOG2),
    .ACCEL_WARN (ACCEL_WARN),
    .ACCEL_ALARM(ACCEL_ALARM),
    .BRAKE_ALARM(BRAKE_ALARM),
    .HYST       (HYST),
    .PERSIST    (PERSIST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model (sample level) ----------------
  typedef struct { int avg; int brake; int age; } pend_t;
  int    m_win[$];
  pend_t m_q[$];
  int    m_avg, m_state, m_pcnt, m_events;
  bit    m_ov, m_last_cw;

  function automatic int sat0(input int x);
    return (x < 0) ? 0 : x;
  endfunction

  task automatic model_eval(input int avg, input int br, input bit clr);
    bit hot, warm, ca, cw, pers;
    int nxt;
    hot  = (avg >= ACCEL_ALARM) || (br >= BRAKE_ALARM);
    warm = (avg >= ACCEL_WARN);
    ca   = (avg < sat0(ACCEL_ALARM - HYST)) && (br < sat0(BRAKE_ALARM - HYST));
    cw   = ca && (avg < sat0(ACCEL_WARN - HYST));
    m_pcnt = hot ? ((m_pcnt + 1 > PERSIST) ? PERSIST : m_pcnt + 1) : 0;
    pers = hot && (m_pcnt == PERSIST);
    nxt  = m_state;
    if (m_state == 0)      nxt = pers ? 2 : ((hot || warm) ? 1 : 0);
    else if (m_state == 1) nxt = pers ? 2 : (cw ? 0 : 1);
    else if (m_state == 2) nxt = ca ? (LATCH ? 3 : 1) : 2;
    else                   nxt = pers ? 2 : ((clr && cw) ? 0 : 3);
    if (nxt == 2 && m_state != 2 && m_events < 255) m_events++;
    m_state   = nxt;
    m_last_cw = cw;
  endtask

  // One rising edge of the model, given what the bench drove for that edge.
  task automatic model_edge(input bit v, input int a, input int b,
                            input bit clr, input bit r);
    bit evald;
    int s;
    if (r) begin
      m_win = '{0, 0, 0, 0};
      m_q.delete();
      m_avg = 0; m_state = 0; m_pcnt = 0; m_events = 0;
      m_ov = 1'b0; m_last_cw = 1'b0;
      return;
    end
    m_ov  = 1'b0;
    evald = 1'b0;
    for (int i = 0; i < m_q.size(); i++) m_q[i].age++;
    if (m_q.size() > 0 && m_q[0].age == 2) begin
      model_eval(m_q[0].avg, m_q[0].brake, clr);
      void'(m_q.pop_front());
      m_ov  = 1'b1;
      evald = 1'b1;
    end
    foreach (m_q[i]) if (m_q[i].age == 1) m_avg = m_q[i].avg;
    if (!evald && LATCH && m_state == 3 && clr && m_last_cw) m_state = 0;
    if (v) begin
      m_win.push_front(a);
      void'(m_win.pop_back());
      s = 0;
      foreach (m_win[i]) s += m_win[i];
      m_q.push_back('{s / (1 << WIN_LOG2), b, 0});
    end
  endtask

  // Drive one cycle starting from a falling edge; returns at the next one.
  task automatic step(input bit v, input int a, input int b,
                      input bit clr, input bit r);
    rst                 = r;
    bus.feat_valid      = v;
    bus.feat_accel_mag  = DW'(a);
    bus.feat_brake_rate = DW'(b);
    bus.alarm_clear     = clr;
    @(posedge clk);
    model_edge(v, a, b, clr, r);
    @(negedge clk);
  endtask

  // Present one sample and wait until its result is on the outputs.
  task automatic sample_and_wait(input int a, input int b);
    step(1'b1, a, b, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    step(1'b1, 3000, 3000, 1'b0, 1'b1);
    step(1'b1, 3000, 3000, 1'b0, 1'b1);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.avg_accel !== 16'd0) begin n_err++; $display("FAIL rst_avg: got %0d want 0", bus.avg_accel); end
    n_vec++; if (bus.state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", bus.state); end
    n_vec++; if ({bus.warn, bus.alarm} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b want 00", {bus.warn, bus.alarm}); end
    n_vec++; if (bus.event_count !== 8'd0) begin n_err++; $display("FAIL rst_events: got %0d want 0", bus.event_count); end
  endtask

  task automatic test_window_avg();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      sample_and_wait(1200, 0);
      n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL win_out_valid k=%0d: got %b want 1", k, bus.out_valid); end
      n_vec++; if (bus.avg_accel !== 16'(300 * k)) begin n_err++; $display("FAIL win_avg k=%0d: got %0d want %0d", k, bus.avg_accel, 300 * k); end
      n_vec++; if (bus.state !== ((k == 4) ? 2'd1 : 2'd0)) begin n_err++; $display("FAIL win_state k=%0d: got %0d want %0d", k, bus.state, (k == 4) ? 1 : 0); end
    end
    step(1'b0, 0, 0, 1'b0, 1'b0);
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL win_pulse: got %b want 0", bus.out_valid); end
    n_vec++; if (bus.warn !== 1'b1) begin n_err++; $display("FAIL win_warn_hold: got %b want 1", bus.warn); end
  endtask

  task automatic test_brake_alarm();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      sample_and_wait(0, 1600);
      n_vec++; if (bus.state !== ((k == 3) ? 2'd2 : 2'd1)) begin n_err++; $display("FAIL brk_state k=%0d: got %0d want %0d", k, bus.state, (k == 3) ? 2 : 1); end
      n_vec++; if (bus.alarm !== (k == 3)) begin n_err++; $display("FAIL brk_alarm k=%0d: got %b want %b", k, bus.alarm, k == 3); end
      n_vec++; if (bus.event_count !== ((k == 3) ? 8'd1 : 8'd0)) begin n_err++; $display("FAIL brk_events k=%0d: got %0d want %0d", k, bus.event_count, (k == 3) ? 1 : 0); end
    end
  endtask

  // Runs from the ALARM state left by test_brake_alarm.
  task automatic test_hysteresis();
    sample_and_wait(0, 1450);
    n_vec++; if (bus.state !== 2'd2) begin n_err++; $display("FAIL hys_hold_alarm: got %0d want 2", bus.state); end
    sample_and_wait(0, 1390);
    n_vec++; if (bus.state !== (LATCH ? 2'd3 : 2'd1)) begin n_err++; $display("FAIL hys_exit: got %0d want %0d", bus.state, LATCH ? 3 : 1); end
    sample_and_wait(0, 0);
    n_vec++; if (bus.state !== (LATCH ? 2'd3 : 2'd0)) begin n_err++; $display("FAIL hys_cool: got %0d want %0d", bus.state, LATCH ? 3 : 0); end
    n_vec++; if (bus.alarm !== LATCH) begin n_err++; $display("FAIL hys_alarm: got %b want %b", bus.alarm, LATCH); end
  endtask

  task automatic test_latch();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) sample_and_wait(0, 1600);
    sample_and_wait(0, 0);
    n_vec++; if (bus.state !== (LATCH ? 2'd3 : 2'd1)) begin n_err++; $display("FAIL lat_state: got %0d want %0d", bus.state, LATCH ? 3 : 1); end
    n_vec++; if (bus.alarm !== LATCH) begin n_err++; $display("FAIL lat_alarm: got %b want %b", bus.alarm, LATCH); end
    step(1'b0, 0, 0, 1'b1, 1'b0);
    n_vec++; if (bus.state !== (LATCH ? 2'd0 : 2'd1)) begin n_err++; $display("FAIL lat_clear: got %0d want %0d", bus.state, LATCH ? 0 : 1); end
    n_vec++; if (bus.alarm !== 1'b0) begin n_err++; $display("FAIL lat_clear_alarm: got %b want 0", bus.alarm); end
  endtask

  task automatic test_reset_inflight();
    step(1'b0, 0, 0, 1'b0, 1'b1);
    step(1'b1, 3000, 1600, 1'b0, 1'b0);
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 0, 0, 1'b0, 1'b0);
      n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL inf_out_valid c=%0d: got %b want 0", k, bus.out_valid); end
    end
    n_vec++; if (bus.avg_accel !== 16'd0) begin n_err++; $display("FAIL inf_avg: got %0d want 0", bus.avg_accel); end
    n_vec++; if (bus.event_count !== 8'd0) begin n_err++; $display("FAIL inf_events: got %0d want 0", bus.event_count); end
  endtask

  task automatic test_back_to_back();
    int a, b, mode;
    bit v, c, r;
    step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) mode = $urandom_range(0, 2);
      v = ($urandom_range(0, 9) < ((mode == 2) ? 3 : 8));
      case (mode)
        0:       a = $urandom_range(0, 3000);
        1:       a = $urandom_range(800, 2300);
        default: a = $urandom_range(0, 65535);
      endcase
      b = ($urandom_range(0, 3) == 0) ? $urandom_range(1300, 1700) : $urandom_range(0, 1600);
      c = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 599) == 0);
      step(v, a, b, c, r);
      n_vec++; if (bus.out_valid !== m_ov) begin n_err++; $display("FAIL rnd_out_valid i=%0d: got %b want %b", i, bus.out_valid, m_ov); end
      n_vec++; if (bus.avg_accel !== 16'(m_avg)) begin n_err++; $display("FAIL rnd_avg i=%0d: got %0d want %0d", i, bus.avg_accel, m_avg); end
      n_vec++; if (bus.state !== 2'(m_state)) begin n_err++; $display("FAIL rnd_state i=%0d: got %0d want %0d", i, bus.state, m_state); end
      n_vec++; if ({bus.warn, bus.alarm} !== {m_state == 1, m_state >= 2}) begin n_err++; $display("FAIL rnd_flags i=%0d: got %b want %b", i, {bus.warn, bus.alarm}, {m_state == 1, m_state >= 2}); end
      n_vec++; if (bus.event_count !== 8'(m_events)) begin n_err++; $display("FAIL rnd_events i=%0d: got %0d want %0d", i, bus.event_count, m_events); end
    end
  endtask

  initial begin
    rst                 = 1'b1;
    bus.feat_valid      = 1'b0;
    bus.feat_accel_mag  = '0;
    bus.feat_brake_rate = '0;
    bus.alarm_clear     = 1'b0;
    @(negedge clk);
    test_reset();
    test_window_avg();
    test_brake_alarm();
    test_hysteresis();
    test_latch();
    test_reset_inflight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
